// File: rtl/ptosda_pkg.sv
// rtl/ptosda_pkg.sv - shared one-hot state encodings and frame constants for the scl/sda link
// Shared with the downstream decoder bench; TX_PARITY_EN frames use FRAME_LEN_PAR.
package ptosda_pkg;

  localparam int NBITS_DEF     = 4;
  localparam int FRAME_LEN     = 2 + 2 * NBITS_DEF + 3;
  localparam int FRAME_LEN_PAR = 2 + 2 * (NBITS_DEF + 1) + 3;

  typedef enum logic [7:0] {
    S_IDLE     = 8'b0000_0001,
    S_START    = 8'b0000_0010,
    S_START_LO = 8'b0000_0100,
    S_BIT_LO   = 8'b0000_1000,
    S_BIT_HI   = 8'b0001_0000,
    S_STOP_LO  = 8'b0010_0000,
    S_STOP_HI  = 8'b0100_0000,
    S_STOP     = 8'b1000_0000
  } state_e;

endpackage

// File: rtl/ptosda_tx.sv
// rtl/ptosda_tx.sv - nibble-to-scl/sda frame transmitter (start, NBITS data MSB first, stop)
// Optional macro TX_PARITY_EN appends an even-parity bit after the data bits.
module ptosda_tx
  import ptosda_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic [NBITS-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             scl,
  output logic             sda,
  output logic             done
);

  localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

  state_e           state_q, state_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             scl_q, scl_d;
  logic             sda_q, sda_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
`ifdef TX_PARITY_EN
  logic             par_bit_q, par_bit_d;
  logic             par_phase_q, par_phase_d;
`endif

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
`ifdef TX_PARITY_EN
      par_bit_q   <= 1'b0;
      par_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
`ifdef TX_PARITY_EN
      par_bit_q   <= par_bit_d;
      par_phase_q <= par_phase_d;
`endif
    end
  end

  always_comb begin
    state_d     = S_IDLE;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
`ifdef TX_PARITY_EN
    par_bit_d   = par_bit_q;
    par_phase_d = par_phase_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid && ready_q) begin
          state_d = S_START;
          shift_d = data;
          cnt_d   = '0;
`ifdef TX_PARITY_EN
          par_bit_d   = ^data;
          par_phase_d = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START:    state_d = S_START_LO;
      S_START_LO: state_d = S_BIT_LO;
      S_BIT_LO:   state_d = S_BIT_HI;
      S_BIT_HI: begin
`ifdef TX_PARITY_EN
        if (par_phase_q) begin
          state_d     = S_STOP_LO;
          par_phase_d = 1'b0;
        end else if (cnt_q == LAST_CNT) begin
          // Parity rides through the shift MSB so BIT_LO/BIT_HI stay unchanged.
          state_d              = S_BIT_LO;
          cnt_d                = '0;
          par_phase_d          = 1'b1;
          shift_d              = '0;
          shift_d[NBITS-1]     = par_bit_q;
        end else begin
          state_d = S_BIT_LO;
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + 1'b1;
        end
`else
        if (cnt_q == LAST_CNT) begin
          state_d = S_STOP_LO;
          cnt_d   = '0;
        end else begin
          state_d = S_BIT_LO;
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      S_STOP_LO:  state_d = S_STOP_HI;
      S_STOP_HI:  state_d = S_STOP;
      S_STOP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    scl_d   = 1'b1;
    sda_d   = 1'b1;
    ready_d = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_IDLE:     ready_d = 1'b1;
      S_START:    sda_d   = 1'b0;
      S_START_LO: begin
        scl_d = 1'b0;
        sda_d = 1'b0;
      end
      S_BIT_LO: begin
        scl_d = 1'b0;
        sda_d = shift_d[NBITS-1];
      end
      S_BIT_HI:   sda_d   = shift_d[NBITS-1];
      S_STOP_LO: begin
        scl_d = 1'b0;
        sda_d = 1'b0;
      end
      S_STOP_HI:  sda_d   = 1'b0;
      S_STOP:     done_d  = 1'b1;
      default:    ready_d = 1'b1;
    endcase
  end

  assign ready = ready_q;
  assign scl   = scl_q;
  assign sda   = sda_q;
  assign done  = done_q;

endmodule

// File: tb/tb_ptosda_tx.sv
// tb/tb_ptosda_tx.sv - self-checking bench for ptosda_tx with a behavioural link decoder
// Expectations follow TX_PARITY_EN when the bench is built with that macro.
module tb_ptosda_tx;
  import ptosda_pkg::*;

`ifdef TX_PARITY_EN
  localparam int NB   = 5;
  localparam int FLEN = FRAME_LEN_PAR;
`else
  localparam int NB   = 4;
  localparam int FLEN = FRAME_LEN;
`endif
  localparam int NW = FLEN + 1;

  logic       sclk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] data = 4'h0;
  logic       valid = 1'b0;
  logic       ready, scl, sda, done;

  ptosda_tx dut (
    .sclk (sclk),
    .rst  (rst),
    .data (data),
    .valid(valid),
    .ready(ready),
    .scl  (scl),
    .sda  (sda),
    .done (done)
  );

  always #5 sclk = ~sclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream decoder model plus frame length / gap monitor, sampled on negedge.
  logic          p_scl = 1'b1, p_sda = 1'b1, p_ready = 1'b1;
  logic          in_frame = 1'b0;
  int            dcnt = 0;
  int            cyc = 0;
  int            start_cyc = 0;
  int            done_cyc = -1;
  logic [NB-1:0] dbits = '0;
  logic [15:0]   oh;
  logic [15:0]   oh_q[$];
  logic [NB-1:0] bits_q[$];
  int            len_q[$];
  int            gap_q[$];

  initial begin
    forever begin
      @(negedge sclk);
      cyc++;
      if (rst) begin
        in_frame = 1'b0;
        dcnt     = 0;
        done_cyc = -1;
      end else begin
        if (p_scl && scl && p_sda && !sda) begin
          in_frame = 1'b1;
          dcnt     = 0;
          dbits    = '0;
        end else if (!p_scl && scl && in_frame) begin
          if (dcnt < NB) begin
            dbits = {dbits[NB-2:0], sda};
            dcnt++;
          end
        end else if (p_scl && scl && !p_sda && sda && in_frame) begin
          in_frame = 1'b0;
          if (dcnt == NB) begin
            oh = '0;
            oh[dbits[NB-1 -: 4]] = 1'b1;
            oh_q.push_back(oh);
            bits_q.push_back(dbits);
          end
        end
        if (p_ready && !ready) begin
          if (done_cyc >= 0) gap_q.push_back(cyc - done_cyc - 1);
          start_cyc = cyc;
        end
        if (done) begin
          len_q.push_back(cyc - start_cyc + 1);
          done_cyc = cyc;
        end
      end
      p_scl   = scl;
      p_sda   = sda;
      p_ready = ready;
    end
  end

  task automatic clear_q();
    oh_q.delete();
    bits_q.delete();
    len_q.delete();
    gap_q.delete();
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge sclk);
      #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic       valid;
    logic [3:0] data;
    logic [3:0] exp;   // {scl, sda, ready, done} after the edge
  } vec_t;

  typedef struct {
    logic [3:0]  data;
    logic [15:0] exp_oh;
  } frm_t;

  vec_t wave[NW];
  frm_t frm[4];

  initial begin
    // Waveform for 4'b1010; busy cycles carry junk data and some valid=1.
    wave[0]  = '{1'b1, 4'hA, 4'b1000};
    wave[1]  = '{1'b0, 4'h5, 4'b0000};
    wave[2]  = '{1'b0, 4'hF, 4'b0100};
    wave[3]  = '{1'b1, 4'h0, 4'b1100};
    wave[4]  = '{1'b1, 4'h3, 4'b0000};
    wave[5]  = '{1'b1, 4'hC, 4'b1000};
    wave[6]  = '{1'b1, 4'h7, 4'b0100};
    wave[7]  = '{1'b1, 4'h1, 4'b1100};
    wave[8]  = '{1'b1, 4'hE, 4'b0000};
    wave[9]  = '{1'b0, 4'h2, 4'b1000};
`ifdef TX_PARITY_EN
    wave[10] = '{1'b0, 4'h9, 4'b0000};
    wave[11] = '{1'b0, 4'h4, 4'b1000};
    wave[12] = '{1'b0, 4'h6, 4'b0000};
    wave[13] = '{1'b0, 4'h8, 4'b1000};
    wave[14] = '{1'b0, 4'hB, 4'b1101};
    wave[15] = '{1'b0, 4'hD, 4'b1110};
`else
    wave[10] = '{1'b0, 4'h9, 4'b0000};
    wave[11] = '{1'b0, 4'h4, 4'b1000};
    wave[12] = '{1'b0, 4'hB, 4'b1101};
    wave[13] = '{1'b0, 4'hD, 4'b1110};
`endif
    frm[0] = '{4'h3, 16'h0008};
    frm[1] = '{4'hC, 16'h1000};
    frm[2] = '{4'h0, 16'h0001};
    frm[3] = '{4'hF, 16'h8000};

    // Reset and idle
    @(posedge sclk);
    #1;
    chk("reset_state", {28'd0, scl, sda, ready, done}, 32'b1110);
    @(posedge sclk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge sclk);
      #1;
      chk("idle", {28'd0, scl, sda, ready, done}, 32'b1110);
    end

    // Cycle-exact frame for 4'b1010
    clear_q();
    for (int i = 0; i < NW; i++) begin
      valid = wave[i].valid;
      data  = wave[i].data;
      @(posedge sclk);
      #1;
      chk($sformatf("wave[%0d]", i), {28'd0, scl, sda, ready, done}, {28'd0, wave[i].exp});
    end
    @(posedge sclk);
    #1;
    chk("wave_oh_count", oh_q.size(), 1);
    chk("wave_oh", 32'(oh_q[0]), 32'h0400);
    chk("wave_len", len_q[0], FLEN);

    // Back-to-back frames with valid held high
    clear_q();
    valid = 1'b1;
    data  = frm[0].data;
    for (int k = 0; k < 4; k++) begin
      wait_done($sformatf("b2b_done[%0d]", k));
      if (k < 3) data = frm[k+1].data;
      else valid = 1'b0;
    end
    repeat (3) @(posedge sclk);
    #1;
    chk("b2b_count", oh_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b_oh[%0d]", k), 32'(oh_q[k]), 32'(frm[k].exp_oh));
      chk($sformatf("b2b_len[%0d]", k), len_q[k], FLEN);
    end
    for (int k = 1; k < 4; k++) chk($sformatf("b2b_gap[%0d]", k), gap_q[k], 1);

    // Data scrambled mid-frame while valid stays high
    clear_q();
    valid = 1'b1;
    data  = 4'h9;
    @(posedge sclk);
    #1;
    chk("mid_accept", {31'd0, ready}, 32'd0);
    for (int i = 0; i < 40 && !done; i++) begin
      data = 4'($urandom_range(0, 15));
      @(posedge sclk);
      #1;
    end
    chk("mid_done", {31'd0, done}, 32'd1);
    valid = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    chk("mid_oh", 32'(oh_q[0]), 32'h0200);
`ifdef TX_PARITY_EN
    chk("mid_bits", 32'(bits_q[0]), 32'b10010);
`else
    chk("mid_bits", 32'(bits_q[0]), 32'h9);
`endif

    // Reset in BIT_HI of the third data bit (4'b0100 -> sda low there)
    clear_q();
    valid = 1'b1;
    data  = 4'h4;
    @(posedge sclk);
    #1;
    valid = 1'b0;
    repeat (7) @(posedge sclk);
    #1;
    chk("pre_rst_bit_hi", {30'd0, scl, sda}, 32'b10);
    rst = 1'b1;
    @(posedge sclk);
    #1;
    chk("post_rst", {28'd0, scl, sda, ready, done}, 32'b1110);
    rst   = 1'b0;
    valid = 1'b1;
    data  = 4'hF;
    @(posedge sclk);
    #1;
    valid = 1'b0;
    wait_done("rst_frame_done");
    @(posedge sclk);
    #1;
    chk("rst_frame_count", oh_q.size(), 1);
    chk("rst_frame_oh", 32'(oh_q[0]), 32'h8000);
    chk("rst_frame_len", len_q[0], FLEN);

    // 4'b0111: parity bit is 1 when enabled
    clear_q();
    valid = 1'b1;
    data  = 4'h7;
    @(posedge sclk);
    #1;
    valid = 1'b0;
    wait_done("par_done");
    @(posedge sclk);
    #1;
    chk("par_oh", 32'(oh_q[0]), 32'h0080);
`ifdef TX_PARITY_EN
    chk("par_bits", 32'(bits_q[0]), 32'b01111);
    chk("par_len", len_q[0], 15);
`else
    chk("par_bits", 32'(bits_q[0]), 32'b0111);
    chk("par_len", len_q[0], 13);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
